display_scheduler: RTL
======================

DISPLAY_SCHEDULER -- requirements
Module: display_scheduler

Interface
REQ-001 The block SHALL have parameter SEGMENT_NUM, default 4: number of digits per frame.
REQ-002 The block SHALL have parameter REFRESH_DIV, default 100000: clock cycles per refresh tick, minimum 2.
REQ-003 The block SHALL have parameter BLINK_FRAMES, default 64: frames per blink phase, minimum 1.
REQ-004 The block SHALL have parameter MSG_FRAMES, default 512: frames a message is shown, minimum 1.
REQ-005 The block SHALL have port i_Clk, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-006 The block SHALL have port i_Reset, input, 1 bit: asynchronous, active-high reset.
REQ-007 The block SHALL have port i_Time_BCD, input, 4*SEGMENT_NUM bits: current-time digits; digit 0 is in the LSBs.
REQ-008 The block SHALL have port i_Alarm_BCD, input, 4*SEGMENT_NUM bits: alarm-time digits.
REQ-009 The block SHALL have port i_Alarm_Show, input, 1 bit: level request to show the alarm time.
REQ-010 The block SHALL have port i_Msg_BCD, input, 4*SEGMENT_NUM bits: message digits.
REQ-011 The block SHALL have port i_Msg_Req, input, 1 bit: level request to show a message.
REQ-012 The block SHALL have port i_Blink_Mask, input, SEGMENT_NUM bits: digits to blink.
REQ-013 The block SHALL have port o_Refresh_En, output, 1 bit: one-cycle tick that advances the digit scanner.
REQ-014 The block SHALL have port o_Frame_Start, output, 1 bit: one-cycle pulse on the tick that begins digit 0.
REQ-015 The block SHALL have port o_BCD_Num, output, 4*SEGMENT_NUM bits: selected frame data for the digit scanner.
REQ-016 The block SHALL have port o_Source, output, 2 bits: 0 = TIME, 1 = ALARM, 2 = MSG.
REQ-017 The block SHALL have port o_Msg_Ack, output, 1 bit: one-cycle pulse when the message is accepted.
REQ-018 The block SHALL have port o_Msg_Done, output, 1 bit: one-cycle pulse when the message display ends.

Function
REQ-019 The prescaler SHALL count 0..REFRESH_DIV-1 and assert o_Refresh_En for one cycle when the count equals REFRESH_DIV-1.
REQ-020 The digit counter SHALL count 0..SEGMENT_NUM-1 on each tick and wrap to 0.
REQ-021 o_Frame_Start SHALL be asserted together with the tick whose digit count is 0; this tick is the frame boundary.
REQ-022 o_BCD_Num, o_Source and the state SHALL update only on the clock edge that asserts o_Frame_Start, so the bus is constant within a frame.
REQ-023 The FSM SHALL have states TIME, ALARM and MSG, and SHALL reset to TIME.
REQ-024 At each frame boundary the next state SHALL be chosen as follows:
- from TIME or ALARM: MSG if i_Msg_Req = 1; else ALARM if i_Alarm_Show = 1; else TIME.
- from MSG: stay in MSG until the frame counter expires.
REQ-025 On entry to MSG the block SHALL latch i_Msg_BCD once and pulse o_Msg_Ack in the same cycle as o_Frame_Start.
REQ-026 After MSG_FRAMES complete frames in MSG the block SHALL pulse o_Msg_Done at the next boundary and re-arbitrate at that same boundary.
REQ-027 If i_Msg_Req is still high when MSG ends, the block SHALL re-enter MSG with a fresh ack only if it is high at that boundary; back-to-back messages are allowed.
REQ-028 While in MSG, i_Msg_Req SHALL be ignored.
REQ-029 In TIME and ALARM, the selected source SHALL be re-sampled at every frame boundary (live update).
REQ-030 The blink counter SHALL count frames and toggle the blink phase every BLINK_FRAMES frames; the phase SHALL be visible after reset.
REQ-031 In the hidden phase, in TIME and ALARM only, every digit i with i_Blink_Mask[i] = 1 SHALL be output as 4'hF (the blank code).
REQ-032 Blinking SHALL never apply in MSG.
REQ-033 The blink counter SHALL keep running across source changes.
REQ-034 A change of i_Alarm_Show or i_Blink_Mask in mid-frame SHALL take effect at the next boundary only.

Reset
REQ-035 While i_Reset is high, all outputs SHALL take their reset values immediately (asynchronously):
- o_Refresh_En = 0, o_Frame_Start = 0, o_Msg_Ack = 0, o_Msg_Done = 0;
- o_Source = 0 (TIME);
- o_BCD_Num = all 4'hF.
REQ-036 While i_Reset is high, the prescaler, digit, frame and blink counters SHALL be 0, and the blink phase SHALL be visible.
REQ-037 A reset during MSG SHALL abort the message with no o_Msg_Done pulse.
REQ-038 After i_Reset deasserts, the first o_Refresh_En and o_Frame_Start SHALL occur on the REFRESH_DIV-th rising edge.

Structure
REQ-039 The state encoding (TIME/ALARM/MSG) and the blank code 4'hF SHALL live in the shared display package, which is also used by the digit scanner and the decoder.
REQ-040 The prescaler SHALL be one sub-module, refresh_prescaler (parameter REFRESH_DIV, output tick); all other logic SHALL be in this module.

Verification
All scenarios use SEGMENT_NUM=4, REFRESH_DIV=4, BLINK_FRAMES=2, MSG_FRAMES=3, so one frame = 16 cycles.
REQ-041 Release reset, i_Time_BCD=16'h1234 -> ticks on cycles 4, 8, 12, ...; o_Frame_Start on cycles 4, 20, 36; o_BCD_Num=16'h1234 from cycle 4, o_Source=0.
REQ-042 Assert i_Alarm_Show mid-frame (cycle 10), i_Alarm_BCD=16'h0630 -> o_BCD_Num stays 16'h1234 until cycle 20, then 16'h0630 with o_Source=1; drop the request -> TIME at the next boundary.
REQ-043 Assert i_Msg_Req and i_Alarm_Show together, i_Msg_BCD=16'hABCD -> at the boundary o_Source=2 and o_Msg_Ack pulses; the bus holds 16'hABCD for 3 frames even if i_Msg_BCD changes; then o_Msg_Done pulses and o_Source=1.
REQ-044 i_Blink_Mask=4'b0011, i_Time_BCD=16'h1234 -> frames 0-1 show 16'h1234, frames 2-3 show 16'h12FF, repeating; a mask applied during MSG leaves the message unblanked.
REQ-045 Assert reset in the second message frame -> outputs go to their reset values immediately with no o_Msg_Done; after release the sequence matches REQ-041.

Source files
------------

// File: rtl/display_scheduler_pkg.sv
// Shared display types: frame source / scheduler state encoding and the blank digit code.
package display_scheduler_pkg;

  typedef enum logic [1:0] {
    StTime  = 2'd0,
    StAlarm = 2'd1,
    StMsg   = 2'd2
  } disp_state_e;

  localparam logic [3:0] BlankCode = 4'hF;

endpackage

// File: rtl/refresh_prescaler.sv
// Free-running divider; tick is high while the count sits at REFRESH_DIV-1.
module refresh_prescaler #(
  parameter int unsigned REFRESH_DIV = 100000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int unsigned CntW = $clog2(REFRESH_DIV);

  logic [CntW-1:0] cnt_q;

  assign tick = (cnt_q == CntW'(REFRESH_DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CntW'(1);
    end
  end

endmodule

// File: rtl/display_scheduler.sv
// Chooses time, alarm or message data for the digit scanner, switching only at frame
// boundaries, with frame-based blinking and timed message display.
module display_scheduler
  import display_scheduler_pkg::*;
#(
  parameter int unsigned SEGMENT_NUM  = 4,
  parameter int unsigned REFRESH_DIV  = 100000,
  parameter int unsigned BLINK_FRAMES = 64,
  parameter int unsigned MSG_FRAMES   = 512
) (
  input  logic                     i_Clk,
  input  logic                     i_Reset,
  input  logic [4*SEGMENT_NUM-1:0] i_Time_BCD,
  input  logic [4*SEGMENT_NUM-1:0] i_Alarm_BCD,
  input  logic                     i_Alarm_Show,
  input  logic [4*SEGMENT_NUM-1:0] i_Msg_BCD,
  input  logic                     i_Msg_Req,
  input  logic [SEGMENT_NUM-1:0]   i_Blink_Mask,
  output logic                     o_Refresh_En,
  output logic                     o_Frame_Start,
  output logic [4*SEGMENT_NUM-1:0] o_BCD_Num,
  output logic [1:0]               o_Source,
  output logic                     o_Msg_Ack,
  output logic                     o_Msg_Done
);

  localparam int unsigned DataW  = 4 * SEGMENT_NUM;
  localparam int unsigned DigitW = (SEGMENT_NUM > 1) ? $clog2(SEGMENT_NUM) : 1;
  localparam int unsigned BlinkW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam int unsigned MsgW   = (MSG_FRAMES > 1) ? $clog2(MSG_FRAMES) : 1;

  logic tick;
  logic boundary;
  logic rearb;
  logic [DataW-1:0] src;

  disp_state_e       state_q, state_d;
  logic [DigitW-1:0] digit_q, digit_d;
  logic [BlinkW-1:0] blink_cnt_q, blink_cnt_d;
  logic              blink_hide_q, blink_hide_d;
  logic [MsgW-1:0]   msg_cnt_q, msg_cnt_d;
  logic [DataW-1:0]  bcd_q, bcd_d;
  logic              refresh_q, refresh_d;
  logic              frame_start_q, frame_start_d;
  logic              ack_q, ack_d;
  logic              done_q, done_d;

  refresh_prescaler #(
    .REFRESH_DIV(REFRESH_DIV)
  ) u_prescaler (
    .clk  (i_Clk),
    .rst  (i_Reset),
    .tick (tick)
  );

  // The tick that starts digit 0 is the frame boundary.
  assign boundary = tick && (digit_q == '0);

  always_comb begin
    state_d       = state_q;
    digit_d       = digit_q;
    blink_cnt_d   = blink_cnt_q;
    blink_hide_d  = blink_hide_q;
    msg_cnt_d     = msg_cnt_q;
    bcd_d         = bcd_q;
    refresh_d     = tick;
    frame_start_d = boundary;
    ack_d         = 1'b0;
    done_d        = 1'b0;
    rearb         = 1'b0;
    src           = '0;

    if (tick) begin
      digit_d = (digit_q == DigitW'(SEGMENT_NUM - 1)) ? '0 : digit_q + DigitW'(1);
    end

    if (boundary) begin
      if (blink_cnt_q == BlinkW'(BLINK_FRAMES - 1)) begin
        blink_cnt_d  = '0;
        blink_hide_d = ~blink_hide_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BlinkW'(1);
      end

      rearb = 1'b1;
      if (state_q == StMsg) begin
        if (msg_cnt_q == MsgW'(MSG_FRAMES - 1)) begin
          done_d = 1'b1;
        end else begin
          msg_cnt_d = msg_cnt_q + MsgW'(1);
          rearb     = 1'b0;
        end
      end

      if (rearb) begin
        if (i_Msg_Req) begin
          state_d   = StMsg;
          msg_cnt_d = '0;
          ack_d     = 1'b1;
          bcd_d     = i_Msg_BCD;
        end else begin
          state_d = i_Alarm_Show ? StAlarm : StTime;
          src     = i_Alarm_Show ? i_Alarm_BCD : i_Time_BCD;
          // The phase in force for this frame is the current one, not the toggled one.
          for (int unsigned i = 0; i < SEGMENT_NUM; i++) begin
            bcd_d[4*i +: 4] = (blink_hide_q && i_Blink_Mask[i]) ? BlankCode : src[4*i +: 4];
          end
        end
      end
    end
  end

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      state_q       <= StTime;
      digit_q       <= '0;
      blink_cnt_q   <= '0;
      blink_hide_q  <= 1'b0;
      msg_cnt_q     <= '0;
      bcd_q         <= {SEGMENT_NUM{BlankCode}};
      refresh_q     <= 1'b0;
      frame_start_q <= 1'b0;
      ack_q         <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      digit_q       <= digit_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_hide_q  <= blink_hide_d;
      msg_cnt_q     <= msg_cnt_d;
      bcd_q         <= bcd_d;
      refresh_q     <= refresh_d;
      frame_start_q <= frame_start_d;
      ack_q         <= ack_d;
      done_q        <= done_d;
    end
  end

  assign o_Refresh_En  = refresh_q;
  assign o_Frame_Start = frame_start_q;
  assign o_BCD_Num     = bcd_q;
  assign o_Source      = state_q;
  assign o_Msg_Ack     = ack_q;
  assign o_Msg_Done    = done_q;

endmodule
